phys_reg_read_stage: RTL and testbench
======================================

Name: phys_reg_read_stage

Overview:
- Parametrised successor to the single-write, three-read physical register read stage.
- Contents: physical register array, busy scoreboard, N read ports, M write ports.
- Read results sit in a one-deep valid/ready pipeline register. While that register is held, writeback wakes up held operands.
- Sits between rename/issue and execute.

Parameters:
- NUM_PHYS_REGS, 64: physical register count, power of two, at least 4; LOG_PHYS = $clog2(NUM_PHYS_REGS).
- DATA_WIDTH, 32: register width in bits.
- NUM_READ, 3: read ports (operands per issued op), 1 to 4.
- NUM_WRITE, 2: writeback ports, 1 to 4.

Ports:
- CLK  in  1  clock, all state changes on posedge.
- RESET  in  1  synchronous, active-low reset (RESET==0 at posedge resets).
- Valid_IN  in  1  upstream op valid.
- Ready_OUT  out  1  stage can accept = !Valid_OUT || Ready_IN (combinational).
- RegAddr_IN  in  NUM_READ*LOG_PHYS  packed read addresses, port i at [i*LOG_PHYS +: LOG_PHYS].
- WrEn_IN  in  NUM_WRITE  per-port write enable.
- WrAddr_IN  in  NUM_WRITE*LOG_PHYS  packed write addresses.
- WrData_IN  in  NUM_WRITE*DATA_WIDTH  packed write data.
- BusyReg_IN  in  LOG_PHYS  register to mark busy.
- SetBusy_IN  in  1  mark BusyReg_IN busy.
- FreeReg_IN  in  LOG_PHYS  register to mark free.
- SetFree_IN  in  1  mark FreeReg_IN free.
- Valid_OUT  out  1  output register holds an op.
- Ready_IN  in  1  downstream accepts.
- RegValue_OUT  out  NUM_READ*DATA_WIDTH  captured operand values, registered.
- OpReady_OUT  out  NUM_READ  per-operand "value is final", registered.
- Busy_list_OUT  out  NUM_PHYS_REGS  busy bit per physical register, registered.

Behaviour:
- Reset (RESET==0 at posedge):
  - Valid_OUT=0, RegValue_OUT=0, OpReady_OUT=0, Busy_list_OUT=0.
  - All array entries cleared to 0.
  - Reset overrides all concurrent inputs and discards any in-flight op.
- Array write: for each k with WrEn_IN[k], entry WrAddr_k <= WrData_k at posedge. If several ports hit the same address, the highest k wins.
- Busy bit b[r], next state:
  - SetBusy_IN && BusyReg_IN==r gives 1. Set has priority over any clear.
  - Otherwise a write to r on any port, or SetFree_IN && FreeReg_IN==r, gives 0.
  - Otherwise hold.
- Capture: fire = Valid_IN && Ready_OUT. One-cycle latency; at the posedge after fire:
  - Valid_OUT=1.
  - Each operand i stores the array value and OpReady_i = !b[addr_i], both using pre-edge state (bypass case in Optional Feature).
  - The stage also stores the captured addresses internally.
- Drain: Valid_OUT && Ready_IN && !fire clears Valid_OUT at the next posedge. Fire and drain in the same cycle gives back-to-back ops with no bubble.
- Hold: while Valid_OUT && !Ready_IN, RegValue_OUT and the addresses stay stable, except wakeup.
  - Wakeup: any operand with OpReady_i==0 whose stored address matches an active write port loads that WrData (highest k wins) and sets OpReady_i=1 at the posedge.
  - Operands with OpReady_i==1 never change while held.
- Valid_IN while !Ready_OUT is ignored; upstream holds its inputs.
- OpReady_OUT and RegValue_OUT are don't-care when Valid_OUT==0 but must still be deterministic (hold last value).

Optional Feature:
- Macro: PHYS_REG_WRITE_BYPASS_EN.
- Defined: on a fire cycle, if any active write port targets addr_i, operand i captures that WrData (highest k wins) with OpReady_i=1, regardless of b.
- Undefined: capture uses pre-edge array and busy state only. A same-cycle write is visible only through hold-wakeup or later reads. The consumer replays ops issued with OpReady_i=0.

Decomposition:
- Shared package phys_reg_pkg: LOG_PHYS derivation helper, default width/count constants, phys-reg address typedef, and the packed-slice index function.
- Sub-module phys_reg_array: a NUM_WRITE-write, NUM_READ-read combinational-read array holding the priority write. The busy scoreboard and pipeline register stay in the top.

Test Plan:
- Reset: write 0xDEAD to reg 5, assert RESET=0 for one edge, read reg 5 -> value 0, Busy_list_OUT==0, Valid_OUT==0.
- Basic read: write 0x11 to r3 and 0x22 to r9, then fire with addrs {3,9,0} -> next cycle Valid_OUT=1, values {0x11,0x22,0x0}, OpReady=3'b111.
- Busy/wakeup: SetBusy r7, fire reading r7 with Ready_IN=0 -> OpReady_0=0. Write 0xABCD to r7 on port 1 -> next cycle value 0xABCD, OpReady_0=1, b[7]=0.
- Priority: same cycle SetBusy r4 + SetFree r4 + write r4 -> b[4]=1. Ports 0 and 1 both write r2 (0x1, 0x2) -> r2 reads 0x2.
- Back-to-back and backpressure: 4 consecutive fires with Ready_IN toggling 1,0,1,1 -> no op lost or duplicated, Ready_OUT=0 exactly in the held cycle.
- Bypass: fire reading r6 while writing 0x55 to r6 -> with the macro 0x55/OpReady=1; without it the old value and OpReady = !b[6].

Source files
------------

// File: rtl/phys_reg_pkg.sv
// Shared definitions for the physical register read stage: default sizes,
// address typedef and packed-slice helpers.
package phys_reg_pkg;

  function automatic int log_phys(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_NUM_PHYS_REGS = 64;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_NUM_READ      = 3;
  localparam int DEF_NUM_WRITE     = 2;
  localparam int DEF_LOG_PHYS      = log_phys(DEF_NUM_PHYS_REGS);

  typedef logic [DEF_LOG_PHYS-1:0] phys_addr_t;

  // Low bit of port `port` in a packed bus of `width`-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/phys_reg_array.sv
// Multi-write, multi-read physical register array with combinational reads.
// Same-address writes in one cycle resolve to the highest-numbered port.
module phys_reg_array
  import phys_reg_pkg::*;
#(
  parameter int NUM_PHYS_REGS = DEF_NUM_PHYS_REGS,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUM_READ      = DEF_NUM_READ,
  parameter int NUM_WRITE     = DEF_NUM_WRITE,
  parameter int LOG_PHYS      = log_phys(NUM_PHYS_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_WRITE-1:0]           wr_en,
  input  logic [NUM_WRITE*LOG_PHYS-1:0]  wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_READ*LOG_PHYS-1:0]   rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [NUM_PHYS_REGS];

  // Later loop iterations overwrite earlier ones, so the highest port wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_PHYS_REGS; r++) mem[r] <= '0;
    end else begin
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (wr_en[k])
          mem[wr_addr[slice_lo(k, LOG_PHYS) +: LOG_PHYS]] <=
            wr_data[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_READ; i++)
      rd_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] =
        mem[rd_addr[slice_lo(i, LOG_PHYS) +: LOG_PHYS]];
  end

endmodule

// File: rtl/phys_reg_read_stage.sv
// Physical register read stage: array, busy scoreboard and a one-deep
// valid/ready output register with writeback wakeup. Optional same-cycle
// write bypass on capture is enabled by defining PHYS_REG_WRITE_BYPASS_EN.
module phys_reg_read_stage
  import phys_reg_pkg::*;
#(
  parameter int NUM_PHYS_REGS = DEF_NUM_PHYS_REGS,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUM_READ      = DEF_NUM_READ,
  parameter int NUM_WRITE     = DEF_NUM_WRITE,
  parameter int LOG_PHYS      = log_phys(NUM_PHYS_REGS)
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            Valid_IN,
  output logic                            Ready_OUT,
  input  logic [NUM_READ*LOG_PHYS-1:0]    RegAddr_IN,
  input  logic [NUM_WRITE-1:0]            WrEn_IN,
  input  logic [NUM_WRITE*LOG_PHYS-1:0]   WrAddr_IN,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] WrData_IN,
  input  logic [LOG_PHYS-1:0]             BusyReg_IN,
  input  logic                            SetBusy_IN,
  input  logic [LOG_PHYS-1:0]             FreeReg_IN,
  input  logic                            SetFree_IN,
  output logic                            Valid_OUT,
  input  logic                            Ready_IN,
  output logic [NUM_READ*DATA_WIDTH-1:0]  RegValue_OUT,
  output logic [NUM_READ-1:0]             OpReady_OUT,
  output logic [NUM_PHYS_REGS-1:0]        Busy_list_OUT
);

  // Handshake: an op moves on a posedge where valid and ready are both high;
  // the producer holds its payload stable until that edge, and ready may
  // depend combinationally on the downstream ready.
  logic                           valid_q;
  logic [NUM_PHYS_REGS-1:0]       busy_q;
  logic [NUM_PHYS_REGS-1:0]       busy_next;
  logic [NUM_READ*LOG_PHYS-1:0]   addr_q;
  logic [NUM_READ*DATA_WIDTH-1:0] value_q;
  logic [NUM_READ-1:0]            op_ready_q;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
  logic [NUM_READ*DATA_WIDTH-1:0] cap_value;
  logic [NUM_READ-1:0]            cap_ready;
  logic [NUM_READ*DATA_WIDTH-1:0] wake_value;
  logic [NUM_READ-1:0]            wake_hit;
  logic                           fire;
  logic                           held;

  assign Ready_OUT     = !valid_q || Ready_IN;
  assign fire          = Valid_IN && Ready_OUT;
  assign held          = valid_q && !Ready_IN;
  assign Valid_OUT     = valid_q;
  assign RegValue_OUT  = value_q;
  assign OpReady_OUT   = op_ready_q;
  assign Busy_list_OUT = busy_q;

  phys_reg_array #(
    .NUM_PHYS_REGS(NUM_PHYS_REGS),
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_READ     (NUM_READ),
    .NUM_WRITE    (NUM_WRITE),
    .LOG_PHYS     (LOG_PHYS)
  ) u_array (
    .clk    (CLK),
    .rst_n  (RESET),
    .wr_en  (WrEn_IN),
    .wr_addr(WrAddr_IN),
    .wr_data(WrData_IN),
    .rd_addr(RegAddr_IN),
    .rd_data(rd_data)
  );

  // Set beats any clear in the same cycle.
  always_comb begin
    busy_next = busy_q;
    for (int r = 0; r < NUM_PHYS_REGS; r++) begin
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (WrEn_IN[k] && WrAddr_IN[slice_lo(k, LOG_PHYS) +: LOG_PHYS] == LOG_PHYS'(r))
          busy_next[r] = 1'b0;
      end
      if (SetFree_IN && FreeReg_IN == LOG_PHYS'(r)) busy_next[r] = 1'b0;
      if (SetBusy_IN && BusyReg_IN == LOG_PHYS'(r)) busy_next[r] = 1'b1;
    end
  end

  always_comb begin
    cap_value = rd_data;
    cap_ready = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      cap_ready[i] = !busy_q[RegAddr_IN[slice_lo(i, LOG_PHYS) +: LOG_PHYS]];
`ifdef PHYS_REG_WRITE_BYPASS_EN
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (WrEn_IN[k] && WrAddr_IN[slice_lo(k, LOG_PHYS) +: LOG_PHYS] ==
                          RegAddr_IN[slice_lo(i, LOG_PHYS) +: LOG_PHYS]) begin
          cap_value[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] =
            WrData_IN[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
          cap_ready[i] = 1'b1;
        end
      end
`endif
    end
  end

  // Wakeup match against the stored addresses; highest write port wins.
  always_comb begin
    wake_hit   = '0;
    wake_value = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (WrEn_IN[k] && WrAddr_IN[slice_lo(k, LOG_PHYS) +: LOG_PHYS] ==
                          addr_q[slice_lo(i, LOG_PHYS) +: LOG_PHYS]) begin
          wake_hit[i] = 1'b1;
          wake_value[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] =
            WrData_IN[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      valid_q    <= 1'b0;
      busy_q     <= '0;
      addr_q     <= '0;
      value_q    <= '0;
      op_ready_q <= '0;
    end else begin
      valid_q <= fire || held;
      busy_q  <= busy_next;
      if (fire) begin
        addr_q     <= RegAddr_IN;
        value_q    <= cap_value;
        op_ready_q <= cap_ready;
      end else if (held) begin
        for (int i = 0; i < NUM_READ; i++) begin
          if (!op_ready_q[i] && wake_hit[i]) begin
            value_q[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] <=
              wake_value[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
            op_ready_q[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_read_stage.sv
// Directed bench for phys_reg_read_stage with default parameters; honours
// PHYS_REG_WRITE_BYPASS_EN for the same-cycle capture case.
module tb_phys_reg_read_stage;
  import phys_reg_pkg::*;

  localparam int NPR = 64;
  localparam int DW  = 32;
  localparam int NR  = 3;
  localparam int NW  = 2;
  localparam int LP  = 6;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              Valid_IN;
  logic              Ready_OUT;
  logic [NR*LP-1:0]  RegAddr_IN;
  logic [NW-1:0]     WrEn_IN;
  logic [NW*LP-1:0]  WrAddr_IN;
  logic [NW*DW-1:0]  WrData_IN;
  logic [LP-1:0]     BusyReg_IN;
  logic              SetBusy_IN;
  logic [LP-1:0]     FreeReg_IN;
  logic              SetFree_IN;
  logic              Valid_OUT;
  logic              Ready_IN;
  logic [NR*DW-1:0]  RegValue_OUT;
  logic [NR-1:0]     OpReady_OUT;
  logic [NPR-1:0]    Busy_list_OUT;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  phys_reg_read_stage dut (
    .CLK(CLK), .RESET(RESET), .Valid_IN(Valid_IN), .Ready_OUT(Ready_OUT),
    .RegAddr_IN(RegAddr_IN), .WrEn_IN(WrEn_IN), .WrAddr_IN(WrAddr_IN),
    .WrData_IN(WrData_IN), .BusyReg_IN(BusyReg_IN), .SetBusy_IN(SetBusy_IN),
    .FreeReg_IN(FreeReg_IN), .SetFree_IN(SetFree_IN), .Valid_OUT(Valid_OUT),
    .Ready_IN(Ready_IN), .RegValue_OUT(RegValue_OUT), .OpReady_OUT(OpReady_OUT),
    .Busy_list_OUT(Busy_list_OUT)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic idle();
    Valid_IN = 1'b0; RegAddr_IN = '0; WrEn_IN = '0; WrAddr_IN = '0; WrData_IN = '0;
    BusyReg_IN = '0; SetBusy_IN = 1'b0; FreeReg_IN = '0; SetFree_IN = 1'b0;
    Ready_IN = 1'b1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_wr(input int k, input phys_addr_t a, input logic [DW-1:0] d);
    WrEn_IN[k] = 1'b1;
    WrAddr_IN[k*LP +: LP] = a;
    WrData_IN[k*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input phys_addr_t a);
    RegAddr_IN[i*LP +: LP] = a;
  endtask

  function automatic logic [DW-1:0] val(input int i);
    return RegValue_OUT[i*DW +: DW];
  endfunction

  initial begin
    int  j;
    int  held_cycles;
    bit  mv;
    bit  fire_m;
    logic [3:0] pat;
    logic [DW-1:0] e;

    idle();
    RESET = 1'b0;
    step(); step();
    RESET = 1'b1;

    // reset discards a held op, busy bits and array contents
    set_wr(0, 6'd5, 32'hDEAD); step(); idle();
    SetBusy_IN = 1'b1; BusyReg_IN = 6'd5;
    Valid_IN = 1'b1; set_rd(0, 6'd5); Ready_IN = 1'b0;
    step(); idle(); Ready_IN = 1'b0;
    check("pre_reset_val", val(0), 32'hDEAD);
    check("pre_reset_busy", Busy_list_OUT, 64'h20);
    RESET = 1'b0; Valid_IN = 1'b1;
    step(); idle(); RESET = 1'b1;
    check("rst_valid", Valid_OUT, 0);
    check("rst_busy", Busy_list_OUT, 0);
    check("rst_value", RegValue_OUT, 0);
    check("rst_opready", OpReady_OUT, 0);
    Valid_IN = 1'b1; set_rd(0, 6'd5); step(); idle();
    check("rst_r5_read", val(0), 0);
    check("rst_r5_valid", Valid_OUT, 1);
    step();
    check("drain_valid", Valid_OUT, 0);

    // basic read of two written registers
    set_wr(0, 6'd3, 32'h11); set_wr(1, 6'd9, 32'h22); step(); idle();
    Valid_IN = 1'b1; set_rd(0, 6'd3); set_rd(1, 6'd9); set_rd(2, 6'd0);
    step(); idle();
    check("basic_valid", Valid_OUT, 1);
    check("basic_value", RegValue_OUT, {32'h0, 32'h22, 32'h11});
    check("basic_opready", OpReady_OUT, 3'b111);
    step();
    check("basic_drain", Valid_OUT, 0);

    // busy operand woken up by writeback while held
    SetBusy_IN = 1'b1; BusyReg_IN = 6'd7; step(); idle();
    check("busy_r7", Busy_list_OUT, 64'h80);
    Valid_IN = 1'b1; set_rd(0, 6'd7); Ready_IN = 1'b0;
    step(); idle(); Ready_IN = 1'b0;
    check("held_opready", OpReady_OUT, 3'b110);
    check("held_ready_out", Ready_OUT, 0);
    set_wr(1, 6'd7, 32'hABCD); step(); idle(); Ready_IN = 1'b0;
    check("wake_value", RegValue_OUT, {32'h0, 32'h0, 32'hABCD});
    check("wake_opready", OpReady_OUT, 3'b111);
    check("wake_busy", Busy_list_OUT, 0);
    check("wake_valid", Valid_OUT, 1);
    Ready_IN = 1'b1; step();
    check("wake_drain", Valid_OUT, 0);

    // set beats clear; highest write port wins
    SetBusy_IN = 1'b1; BusyReg_IN = 6'd4; SetFree_IN = 1'b1; FreeReg_IN = 6'd4;
    set_wr(0, 6'd4, 32'h44); step(); idle();
    check("prio_busy", Busy_list_OUT, 64'h10);
    set_wr(0, 6'd2, 32'h1); set_wr(1, 6'd2, 32'h2); step(); idle();
    Valid_IN = 1'b1; set_rd(0, 6'd2); set_rd(1, 6'd4); step(); idle();
    check("prio_value", RegValue_OUT, {32'h0, 32'h44, 32'h2});
    check("prio_opready", OpReady_OUT, 3'b101);
    SetFree_IN = 1'b1; FreeReg_IN = 6'd4; step(); idle();
    check("free_r4", Busy_list_OUT, 0);

    // back-to-back ops under backpressure pattern 1,0,1,1
    set_wr(0, 6'd10, 32'hA0); set_wr(1, 6'd11, 32'hA1); step(); idle();
    set_wr(0, 6'd12, 32'hA2); set_wr(1, 6'd13, 32'hA3); step(); idle();
    pat = 4'b1101;  // bit c is Ready_IN for cycle c
    j = 0; mv = 0; held_cycles = 0;
    for (int cyc = 0; cyc < 20 && (j < 4 || mv); cyc++) begin
      idle();
      Ready_IN = (cyc < 4) ? pat[cyc] : 1'b1;
      Valid_IN = (j < 4);
      set_rd(0, phys_addr_t'(10 + j));
      #1;
      check("b2b_valid", Valid_OUT, mv);
      check("b2b_ready_out", Ready_OUT, !mv || Ready_IN);
      if (!Ready_OUT) held_cycles++;
      if (mv && Ready_IN) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check("b2b_value", val(0), e);
      end
      fire_m = Valid_IN && (!mv || Ready_IN);
      if (fire_m) begin
        exp_q.push_back(32'hA0 + DW'(j));
        j++;
      end
      mv = fire_m || (mv && !Ready_IN);
      step();
    end
    idle();
    check("b2b_issued", j, 4);
    check("b2b_drained", {31'd0, mv} | {31'd0, Valid_OUT}, 0);
    check("b2b_queue_empty", exp_q.size(), 0);
    check("b2b_held_cycles", held_cycles, 1);

    // capture while the same register is being written
    SetBusy_IN = 1'b1; BusyReg_IN = 6'd6; step(); idle();
    Valid_IN = 1'b1; set_rd(0, 6'd6); set_wr(0, 6'd6, 32'h55);
    step(); idle();
`ifdef PHYS_REG_WRITE_BYPASS_EN
    check("bypass_value", val(0), 32'h55);
    check("bypass_opready", OpReady_OUT[0], 1);
`else
    check("bypass_value", val(0), 32'h0);
    check("bypass_opready", OpReady_OUT[0], 0);
`endif
    check("bypass_busy", Busy_list_OUT, 0);
    Valid_IN = 1'b1; set_rd(0, 6'd6); step(); idle();
    check("bypass_reread", val(0), 32'h55);
    check("bypass_reread_rdy", OpReady_OUT[0], 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
